fft_input_loader: RTL
=====================

Name: fft_input_loader

Overview:
Front-end writer for the in-place FFT working memory. Accepts a streaming complex sample frame over a valid/ready handshake and sign-extends each sample to the FFT datapath width. Writes samples into the memory at bit-reversed addresses, then pulses flag_start_FFT to launch the FFT controller. Holds off the next frame until the controller reports done.

Parameters:
bit_width, 29, FFT datapath / memory word width (signed)
IN_WIDTH, 16, input sample width (signed), IN_WIDTH <= bit_width
N, 16, FFT points per frame (power of two)
SIZE, 4, log2(N)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input sample valid
in_ready  output  1  loader can accept a sample
in_re  input  IN_WIDTH  signed real part
in_im  input  IN_WIDTH  signed imaginary part
in_last  input  1  marks final sample of frame
done_i  input  1  FFT controller frame-complete pulse (controller done_o)
mem_wr_en  output  1  memory write strobe
mem_wr_ptr  output  SIZE+1  memory write address, MSB always 0
mem_re  output  bit_width  write data, real
mem_im  output  bit_width  write data, imaginary
flag_start_FFT  output  1  one-cycle start pulse to FFT controller
busy  output  1  frame handed to FFT, loader stalled
frame_err  output  1  one-cycle pulse on frame length mismatch
frame_cnt  output  16  completed frames, wraps at 2^16

Behaviour:
- Single clock domain. Reset is asynchronous, active-low (rst_n); all registers are cleared immediately on assertion.
- Reset values: in_ready=0, mem_wr_en=0, mem_wr_ptr=0, mem_re=0, mem_im=0, flag_start_FFT=0, busy=0, frame_err=0, frame_cnt=0. The state machine resets to LOAD with sample counter cnt=0.
- in_ready is decoded from state: 1 only in LOAD. It first rises in the first cycle after reset release.
- States and transitions:
  - LOAD: on accept (in_valid & in_ready):
    - Register mem_wr_en=1, mem_wr_ptr = {1'b0, bitrev_SIZE(cnt)}, mem_re/mem_im = sign-extended in_re/in_im. Write appears the cycle after accept; latency is 1.
    - cnt increments.
    - Accept with cnt==N-1: go to FLUSH. If in_last=0 on this sample, pulse frame_err; the frame closes regardless.
    - Accept with in_last=1 and cnt<N-1: pulse frame_err, go to FILL.
    - No accept: mem_wr_en=0.
  - FILL: write zero data to each remaining address, bitrev(cnt) for cnt up to N-1, one per cycle, with in_ready=0. After writing N-1, go to FLUSH.
  - FLUSH: one cycle with mem_wr_en=0, so the last write has landed. Go to START.
  - START: flag_start_FFT=1 for exactly one cycle, busy=1. Go to WAIT_FFT.
  - WAIT_FFT: busy=1, in_ready=0. On done_i=1: frame_cnt+1, cnt=0, busy=0 in the next cycle, go to LOAD.
- Minimum spacing from last accept to flag_start_FFT is 2 cycles: write at t+1, start pulse at t+2.
- Bit reversal is over the low SIZE bits only. For N=16: 1→8, 2→4, 3→12, 15→15.
- Sign extension replicates bit IN_WIDTH-1. There is no scaling and no saturation.
- done_i outside WAIT_FFT is ignored.
- in_valid and in_last outside LOAD are ignored.
- in_valid may drop mid-frame; the loader waits indefinitely in LOAD with no timeout.
- in_last on a single-sample frame (cnt=0): frame_err pulse, then addresses bitrev(1..N-1) are zero-filled.
- Reset mid-frame or mid-FFT: the partial frame is discarded, no start pulse is issued, and the loader returns to LOAD with cnt=0.

Test Plan:
- Full frame: N=16, 16 back-to-back samples re=k, im=-k, in_last on k=15 → writes at addresses 0,8,4,12,…,15 with matching data, flag_start_FFT 2 cycles after last accept, frame_err never asserts.
- Sign extension: in_re=16'h8000, in_im=16'h7FFF at k=0 → mem_re=29'h1FFF8000, mem_im=29'h00007FFF at address 0.
- Short frame: in_last on k=5 → frame_err pulses once, addresses bitrev(6..15) are written with 0 on 10 consecutive cycles, then FLUSH and the start pulse.
- Missing in_last: 16 samples with no in_last → frame_err pulse on the 16th accept, start pulse still issued, next frame loads normally.
- Backpressure/handoff: in_valid held high through WAIT_FFT → in_ready=0 and no writes. done_i pulse → frame_cnt=1, in_ready=1 the next cycle. A done_i pulse while in LOAD has no effect.
- Async reset asserted in the middle of sample 7 → all outputs zero immediately, no flag_start_FFT. After release, a fresh frame starts writing at address 0.

Source files
------------

// File: rtl/fft_input_loader.sv
// FFT input loader: streams one complex frame into the in-place FFT memory
// at bit-reversed addresses, zero-fills a short frame, then launches the FFT
// controller and holds off new samples until the controller reports done.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// LOAD     | accepting samples, one memory write per accepted sample
// FILL     | short frame: writing zeros to the remaining addresses
// FLUSH    | last write is on the bus; start pulse is launched next
// START    | flag_start_FFT high for this single cycle
// WAIT_FFT | frame owned by the FFT controller, waiting for done_i

module fft_input_loader #(
  parameter int bit_width = 29,
  parameter int IN_WIDTH  = 16,
  parameter int N         = 16,
  parameter int SIZE      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_re,
  input  logic [IN_WIDTH-1:0]  in_im,
  input  logic                 in_last,
  input  logic                 done_i,
  output logic                 mem_wr_en,
  output logic [SIZE:0]        mem_wr_ptr,
  output logic [bit_width-1:0] mem_re,
  output logic [bit_width-1:0] mem_im,
  output logic                 flag_start_FFT,
  output logic                 busy,
  output logic                 frame_err,
  output logic [15:0]          frame_cnt
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_FILL,
    S_FLUSH,
    S_START,
    S_WAIT_FFT
  } state_t;

  localparam logic [SIZE-1:0] LAST_IDX = SIZE'(N - 1);

  state_t               state;
  logic [SIZE-1:0]      cnt;
  logic                 started;
  logic                 accept;
  logic [bit_width-1:0] ext_re;
  logic [bit_width-1:0] ext_im;

  // Reverse the order of the low SIZE address bits.
  function automatic logic [SIZE-1:0] bitrev(input logic [SIZE-1:0] a);
    logic [SIZE-1:0] r;
    r = '0;
    for (int i = 0; i < SIZE; i++) begin
      r[i] = a[SIZE-1-i];
    end
    return r;
  endfunction

  // started keeps in_ready low until the first clock after reset release,
  // even though the state register already sits in LOAD during reset.
  assign in_ready = started && (state == S_LOAD);
  assign accept   = in_valid && in_ready;

  // Sign extension by casting the signed sample up to the datapath width.
  assign ext_re = bit_width'($signed(in_re));
  assign ext_im = bit_width'($signed(in_im));

  // Frame sequencing FSM with all memory-side and control outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_LOAD;
      cnt            <= '0;
      started        <= 1'b0;
      mem_wr_en      <= 1'b0;
      mem_wr_ptr     <= '0;
      mem_re         <= '0;
      mem_im         <= '0;
      flag_start_FFT <= 1'b0;
      busy           <= 1'b0;
      frame_err      <= 1'b0;
      frame_cnt      <= '0;
    end else begin
      started        <= 1'b1;
      mem_wr_en      <= 1'b0;
      flag_start_FFT <= 1'b0;
      frame_err      <= 1'b0;
      case (state)
        S_LOAD: begin
          if (accept) begin
            mem_wr_en  <= 1'b1;
            mem_wr_ptr <= {1'b0, bitrev(cnt)};
            mem_re     <= ext_re;
            mem_im     <= ext_im;
            cnt        <= cnt + 1'b1;
            if (cnt == LAST_IDX) begin
              // A full frame closes here whether or not in_last was seen.
              frame_err <= ~in_last;
              state     <= S_FLUSH;
            end else if (in_last) begin
              frame_err <= 1'b1;
              state     <= S_FILL;
            end
          end
        end
        S_FILL: begin
          mem_wr_en  <= 1'b1;
          mem_wr_ptr <= {1'b0, bitrev(cnt)};
          mem_re     <= '0;
          mem_im     <= '0;
          cnt        <= cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          flag_start_FFT <= 1'b1;
          busy           <= 1'b1;
          state          <= S_START;
        end
        S_START: begin
          state <= S_WAIT_FFT;
        end
        S_WAIT_FFT: begin
          if (done_i) begin
            frame_cnt <= frame_cnt + 16'd1;
            cnt       <= '0;
            busy      <= 1'b0;
            state     <= S_LOAD;
          end
        end
        default: begin
          state <= S_LOAD;
        end
      endcase
    end
  end

endmodule
